// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: shares the single-line data cache request port between
// NPORTS requesters (load/store unit, page walker, ...).
//
// A granted requester owns the cache until the cache answers with respcyc.
// Every transaction is followed by one forced idle cycle (GAP) so that the
// cache's combinational respcyc has dropped before the next command appears.
//
// Build option:
//   DCACHE_ARB_FIXED_PRIO_EN  defined   -> lowest-indexed requester always wins
//                             undefined -> round-robin starting after last_ff

package CACHE;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } cache_cmd_t;
endpackage

module dcache_req_arbiter #(
    parameter int NPORTS = 2,
    parameter int GW     = (NPORTS > 2) ? $clog2(NPORTS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  CACHE::cache_cmd_t [NPORTS-1:0]    port_cmd,
    input  logic [NPORTS*64-1:0]              port_addr,
    input  logic [NPORTS*64-1:0]              port_data,
    output logic [NPORTS-1:0]                 port_respcyc,
    output logic [63:0]                       port_resp_data,
    output CACHE::cache_cmd_t                 cache_cmd,
    output logic [63:0]                       cache_addr,
    output logic [63:0]                       cache_data,
    input  logic                              cache_respcyc,
    input  logic [63:0]                       cache_resp_data,
    output logic                              busy
);

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    arb_state_t      state_ff;
    logic [GW-1:0]   grant_ff;
    logic [GW-1:0]   last_ff;

    logic [NPORTS-1:0] req;
    logic [63:0]       addr_arr [NPORTS];
    logic [63:0]       data_arr [NPORTS];

    logic              pick_valid;
    logic [GW-1:0]     pick_idx;
    logic              in_busy;

    // Unpack the flat address/data buses and derive one request bit per port.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
            assign req[gi]      = (port_cmd[gi] != CACHE::IDLE);
            assign addr_arr[gi] = port_addr[64*gi +: 64];
            assign data_arr[gi] = port_data[64*gi +: 64];
        end
    endgenerate

`ifdef DCACHE_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest requesting index is the
    // last (and therefore winning) assignment.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (req[GW'(i)]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(i);
            end
        end
    end
`else
    logic [GW:0] cand_sum;

    // Round-robin: candidate k positions after last_ff (k = 1..NPORTS, with
    // wrap). Scanning k downward leaves the nearest requester as the winner;
    // k = NPORTS lands back on last_ff itself, which is lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            cand_sum = {1'b0, last_ff} + (GW+1)'(k);
            if (cand_sum >= (GW+1)'(NPORTS)) begin
                cand_sum = cand_sum - (GW+1)'(NPORTS);
            end
            if (req[cand_sum[GW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_sum[GW-1:0];
            end
        end
    end
`endif

    // Arbitration state machine: ARB -> BUSY (until respcyc or withdrawal) -> GAP -> ARB.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_ff <= ARB;
            grant_ff <= '0;
            last_ff  <= GW'(NPORTS - 1);
        end else begin
            case (state_ff)
                ARB: begin
                    if (pick_valid) begin
                        grant_ff <= pick_idx;
                        last_ff  <= pick_idx;
                        state_ff <= BUSY;
                    end
                end
                BUSY: begin
                    // Completion and a withdrawn request both end the
                    // transaction; only completion produces a strobe.
                    if (cache_respcyc || !req[grant_ff]) begin
                        state_ff <= GAP;
                    end
                end
                GAP: begin
                    state_ff <= ARB;
                end
                default: begin
                    state_ff <= ARB;
                end
            endcase
        end
    end

    assign in_busy = (state_ff == BUSY);
    assign busy    = in_busy;

    // Route the granted port onto the cache only while BUSY; idle otherwise.
    always_comb begin
        cache_cmd  = CACHE::IDLE;
        cache_addr = '0;
        cache_data = '0;
        if (in_busy) begin
            cache_cmd  = port_cmd[grant_ff];
            cache_addr = addr_arr[grant_ff];
            cache_data = data_arr[grant_ff];
        end
    end

    // One-hot completion strobe to the granted port; suppressed while reset
    // is asserted so an aborted transaction never reports completion.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_resp
            assign port_respcyc[gi] = in_busy && (grant_ff == GW'(gi))
                                      && cache_respcyc && !reset;
        end
    endgenerate

    assign port_resp_data = cache_resp_data;

endmodule
